regfile_mp: RTL and testbench

Parametrised multi-port register file with two write ports and two read ports. It adds same-cycle write arbitration, an optional registered read with write-through, an optional hardwired-zero R0 and a sequential bulk-clear engine. It is the datapath's general-purpose register store and replaces the fixed 16x16, single-write register file.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clr_fsm.sv | 58 +++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-engine state
// encodings and default geometry.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential bulk-clear engine: walks a pointer over every entry, one per cycle,
// and reports Busy for the whole walk.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    clr_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            busy_reg  <= (state_next == CLEAR);
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        clr_we     = 1'b0;
        clr_addr   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                clr_we   = 1'b1;
                ptr_next = ptr_reg + ADDR_W'(1);
                // Last entry zeroed on this edge; new Clr requests are ignored until IDLE
                if (&ptr_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = busy_reg;

endmodule

// File: rtl/regfile_mp.sv
// Two-write / two-read register file with port-1 write priority, collision flag,
// optional hardwired-zero entry 0, optional registered read and bulk clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_R0  = 0,
    parameter int READ_REG = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [ADDR_W-1:0] Addr_A,
    input  logic [ADDR_W-1:0] Addr_B,
    output logic [DATA_W-1:0] Src,
    output logic [DATA_W-1:0] Dest,
    input  logic              WR0,
    input  logic [ADDR_W-1:0] Waddr0,
    input  logic [DATA_W-1:0] Wdata0,
    input  logic              WR1,
    input  logic [ADDR_W-1:0] Waddr1,
    input  logic [DATA_W-1:0] Wdata1,
    input  logic              Clr,
    output logic              Busy,
    output logic              Collision
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic              collision_reg;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              we0_ok, we1_ok;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
        .clk      (CLK),
        .rst_n    (RSTn),
        .clr      (Clr),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (Busy)
    );

    assign we0_ok = WR0 && !Busy && !((ZERO_R0 != 0) && (Waddr0 == '0));
    assign we1_ok = WR1 && !Busy && !((ZERO_R0 != 0) && (Waddr1 == '0));

    // Port 1 is written last so it wins a same-address conflict
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (clr_we) begin
                mem_reg[clr_addr] <= '0;
            end
            if (we0_ok) begin
                mem_reg[Waddr0] <= Wdata0;
            end
            if (we1_ok) begin
                mem_reg[Waddr1] <= Wdata1;
            end
        end
    end

    // Flags address conflicts on the request itself, even when the write is masked
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= WR0 && WR1 && (Waddr0 == Waddr1);
        end
    end

    assign Collision  = collision_reg;
    assign rd_addr[0] = Addr_A;
    assign rd_addr[1] = Addr_B;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] rd_comb;

            assign rd_comb = ((ZERO_R0 != 0) && (rd_addr[gi] == '0)) ? '0 : mem_reg[rd_addr[gi]];

            if (READ_REG != 0) begin : g_reg
                logic [DATA_W-1:0] rd_reg;

                // Write-through: capture the value this edge's accepted write stores
                always_ff @(posedge CLK or negedge RSTn) begin
                    if (!RSTn) begin
                        rd_reg <= '0;
                    end else if (we1_ok && (Waddr1 == rd_addr[gi])) begin
                        rd_reg <= Wdata1;
                    end else if (we0_ok && (Waddr0 == rd_addr[gi])) begin
                        rd_reg <= Wdata0;
                    end else begin
                        rd_reg <= rd_comb;
                    end
                end
                assign rd_data[gi] = rd_reg;
            end else begin : g_comb
                assign rd_data[gi] = rd_comb;
            end
        end
    endgenerate

    assign Src  = rd_data[0];
    assign Dest = rd_data[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: drives two instances (plain, and ZERO_R0 with
// registered read) from one stimulus stream and checks both against an array model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  addr_a = '0, addr_b = '0;
    logic        wr0 = 1'b0, wr1 = 1'b0, clr = 1'b0;
    logic [3:0]  waddr0 = '0, waddr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;

    logic [15:0] src0, dest0, src1, dest1;
    logic        busy0, busy1, coll0, coll1;

    typedef struct {
        logic [15:0] s0, d0, s1, d1;
        logic        b, c;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m0 [16];
    logic [15:0] m1 [16];
    int          clear_left = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .READ_REG(0)) dut0 (
        .CLK(clk), .RSTn(rst_n), .Addr_A(addr_a), .Addr_B(addr_b),
        .Src(src0), .Dest(dest0),
        .WR0(wr0), .Waddr0(waddr0), .Wdata0(wdata0),
        .WR1(wr1), .Waddr1(waddr1), .Wdata1(wdata1),
        .Clr(clr), .Busy(busy0), .Collision(coll0)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .READ_REG(1)) dut1 (
        .CLK(clk), .RSTn(rst_n), .Addr_A(addr_a), .Addr_B(addr_b),
        .Src(src1), .Dest(dest1),
        .WR0(wr0), .Waddr0(waddr0), .Wdata0(wdata0),
        .WR1(wr1), .Waddr1(waddr1), .Wdata1(wdata1),
        .Clr(clr), .Busy(busy1), .Collision(coll1)
    );

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m0[i] = '0;
            m1[i] = '0;
        end
        clear_left = 0;
    endtask

    // Apply inputs now and queue what both DUTs must show after the next rising edge
    task automatic drive(input logic w0, input logic [3:0] a0, input logic [15:0] d0,
                         input logic w1, input logic [3:0] a1, input logic [15:0] d1,
                         input logic c, input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        bit   busy_pre;
        wr0 = w0; waddr0 = a0; wdata0 = d0;
        wr1 = w1; waddr1 = a1; wdata1 = d1;
        clr = c; addr_a = ra; addr_b = rb;
        if (!rst_n) begin
            model_reset();
            e = '{s0: 16'h0, d0: 16'h0, s1: 16'h0, d1: 16'h0, b: 1'b0, c: 1'b0};
        end else begin
            busy_pre = (clear_left > 0);
            if (!busy_pre) begin
                if (w0) begin
                    m0[a0] = d0;
                    if (a0 != 0) m1[a0] = d0;
                end
                if (w1) begin
                    m0[a1] = d1;
                    if (a1 != 0) m1[a1] = d1;
                end
            end
            // Registered read sees this edge's writes but not this edge's clear step
            e.s1 = m1[ra];
            e.d1 = m1[rb];
            if (busy_pre) begin
                m0[16 - clear_left] = '0;
                m1[16 - clear_left] = '0;
                clear_left--;
            end else if (c) begin
                clear_left = 16;
            end
            e.s0 = m0[ra];
            e.d0 = m0[rb];
            e.b  = (clear_left > 0);
            e.c  = w0 && w1 && (a0 == a1);
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic w0, input logic [3:0] a0, input logic [15:0] d0,
                         input logic w1, input logic [3:0] a1, input logic [15:0] d1,
                         input logic c, input logic [3:0] ra, input logic [3:0] rb);
        @(negedge clk);
        drive(w0, a0, d0, w1, a1, d1, c, ra, rb);
    endtask

    task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, ra, rb);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL txn %0d %s: got %h expected %h", n_txn, name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                chk("src0",  src0,  e.s0);
                chk("dest0", dest0, e.d0);
                chk("src1",  src1,  e.s1);
                chk("dest1", dest1, e.d1);
                chk("busy0", {15'h0, busy0}, {15'h0, e.b});
                chk("busy1", {15'h0, busy1}, {15'h0, e.b});
                chk("coll0", {15'h0, coll0}, {15'h0, e.c});
                chk("coll1", {15'h0, coll1}, {15'h0, e.c});
                $display("txn %0d A=%0d B=%0d src0=%h dest0=%h src1=%h dest1=%h busy=%b coll=%b",
                         n_txn, addr_a, addr_b, src0, dest0, src1, dest1, busy0, coll0);
            end
        end
    end

    initial begin : stimulus
        logic [3:0]  a0, a1;
        logic [15:0] fill;
        model_reset();

        // Reset held: sweep both read ports over every address
        for (int i = 0; i < 16; i++) begin
            idle(4'(i), 4'(15 - i));
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);

        // Independent writes on both ports, then cross read
        cycle(1'b1, 4'd1, 16'h1234, 1'b1, 4'd7, 16'h5678, 1'b0, 4'd7, 4'd1);
        idle(4'd7, 4'd1);

        // Same-address conflict: port 1 wins, one-cycle Collision
        cycle(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd3, 16'h5555, 1'b0, 4'd3, 4'd3);
        idle(4'd3, 4'd3);
        idle(4'd3, 4'd3);

        // Held read address with a write to it: write-through vs. next-cycle visibility
        idle(4'd5, 4'd5);
        cycle(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h0, 1'b0, 4'd5, 4'd5);
        idle(4'd5, 4'd5);

        // Fill every entry with nonzero data, then bulk clear with a dropped write
        for (int i = 0; i < 8; i++) begin
            fill = 16'h1000 + 16'(i * 2);
            cycle(1'b1, 4'(2 * i), fill | 16'h1, 1'b1, 4'(2 * i + 1), fill + 16'h0101, 1'b0,
                  4'(2 * i), 4'(2 * i + 1));
        end
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 4'd15);
        for (int i = 0; i < 16; i++) begin
            if (i == 4) cycle(1'b1, 4'd2, 16'hFFFF, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 4'(i));
            else        idle(4'(i), 4'd2);
        end
        for (int i = 0; i < 16; i++) begin
            idle(4'(i), 4'(15 - i));
        end

        // Write to entry 0: masked on the ZERO_R0 instance only
        cycle(1'b1, 4'd0, 16'h1111, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
        idle(4'd0, 4'd0);

        // Clear aborted by an asynchronous reset pulse between edges, then a full clear
        cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 4'd7);
        for (int i = 0; i < 4; i++) idle(4'd7, 4'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd7, 4'd1);
        cycle(1'b1, 4'd9, 16'h0909, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 4'd0);
        for (int i = 0; i < 18; i++) idle(4'(i % 16), 4'd9);

        // Randomised traffic with occasional clears and biased address conflicts
        for (int n = 0; n < 400; n++) begin
            a0 = 4'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 1)), a0, 16'($urandom),
                  1'($urandom_range(0, 1)), a1, 16'($urandom),
                  1'($urandom_range(0, 59) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
